// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline scheduler.
// Data width mirrors the core-wide 32-bit datapath.
package pipe_ctrl_pkg;
  localparam int DATA_WID = 32;
  localparam int CNT_W    = 32;
  localparam int MD_CNT_W = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (inc && (count != {WIDTH{1'b1}}))
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline scheduler: register enables, flushes, PC redirect,
// mul/div wait with timeout, and saturating stall/flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_use,
  input  logic                ex_mispredict,
  input  logic [DATA_WID-1:0] ex_redirect_pc,
  input  logic                md_start,
  input  logic                md_done,
  input  logic                mem_req,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                id_ex_write,
  output logic                ex_mem_write,
  output logic                if_id_flush,
  output logic                id_ex_flush,
  output logic                ex_mem_bubble,
  output logic                pc_sel,
  output logic [DATA_WID-1:0] new_pc,
  output logic                md_abort,
  output logic                md_err,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam logic [MD_CNT_W-1:0] MD_LIMIT = MD_CNT_W'(MD_TIMEOUT);

  state_t              state, state_nxt;
  logic [MD_CNT_W-1:0] md_cnt, md_cnt_nxt;
  logic                pend_valid, pend_valid_nxt;
  logic [DATA_WID-1:0] pend_pc, pend_pc_nxt;
  logic                md_err_nxt;
  logic                run_eval;
  logic                flush_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      md_cnt     <= '0;
      pend_valid <= 1'b0;
      md_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      md_cnt     <= md_cnt_nxt;
      pend_valid <= pend_valid_nxt;
      md_err     <= md_err_nxt;
    end
  end

  // Redirect target is only meaningful while pend_valid is set.
  always_ff @(posedge clk) begin
    pend_pc <= pend_pc_nxt;
  end

  always_comb begin
    pc_write       = 1'b0;
    if_id_write    = 1'b0;
    id_ex_write    = 1'b0;
    ex_mem_write   = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_bubble  = 1'b0;
    pc_sel         = 1'b0;
    new_pc         = '0;
    md_abort       = 1'b0;
    state_nxt      = state;
    md_cnt_nxt     = md_cnt;
    pend_valid_nxt = pend_valid;
    pend_pc_nxt    = pend_pc;
    md_err_nxt     = md_err;
    flush_inc      = 1'b0;
    run_eval       = 1'b0;

    if (rst) begin
      case (state)
        RUN: run_eval = 1'b1;

        MEM_WAIT: begin
          if (mem_ready) begin
            run_eval = 1'b1;
          end else if (ex_mispredict) begin
            pend_valid_nxt = 1'b1;
            pend_pc_nxt    = ex_redirect_pc;
          end
        end

        MD_WAIT: begin
          if (md_done) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            state_nxt    = RUN;
          end else if (md_cnt == MD_LIMIT) begin
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            id_ex_write   = 1'b1;
            ex_mem_write  = 1'b1;
            ex_mem_bubble = 1'b1;
            md_abort      = 1'b1;
            md_err_nxt    = 1'b1;
            state_nxt     = RUN;
          end else begin
            ex_mem_write  = 1'b1;
            ex_mem_bubble = 1'b1;
            md_cnt_nxt    = md_cnt + {{(MD_CNT_W-1){1'b0}}, 1'b1};
          end
        end

        default: state_nxt = RUN;
      endcase

      // Normal RUN priority; a MEM_WAIT release lands here with the MMIO stall gone.
      if (run_eval) begin
        if ((state == RUN) && mem_req && !mem_ready) begin
          state_nxt = MEM_WAIT;
          if (ex_mispredict) begin
            pend_valid_nxt = 1'b1;
            pend_pc_nxt    = ex_redirect_pc;
          end
        end else if (md_start) begin
          ex_mem_write  = 1'b1;
          ex_mem_bubble = 1'b1;
          state_nxt     = MD_WAIT;
          md_cnt_nxt    = {{(MD_CNT_W-1){1'b0}}, 1'b1};
        end else if (ex_mispredict || pend_valid) begin
          pc_write       = 1'b1;
          if_id_write    = 1'b1;
          id_ex_write    = 1'b1;
          ex_mem_write   = 1'b1;
          if_id_flush    = 1'b1;
          id_ex_flush    = 1'b1;
          pc_sel         = 1'b1;
          new_pc         = ex_mispredict ? ex_redirect_pc : pend_pc;
          pend_valid_nxt = 1'b0;
          flush_inc      = 1'b1;
          state_nxt      = RUN;
        end else if (ld_use) begin
          id_ex_write  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_write = 1'b1;
          state_nxt    = RUN;
        end else begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_ex_write  = 1'b1;
          ex_mem_write = 1'b1;
          state_nxt    = RUN;
        end
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default-timeout instance and a short-timeout
// instance share the same stimulus.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                ld_use, ex_mispredict, md_start, md_done, mem_req, mem_ready;
  logic [DATA_WID-1:0] ex_redirect_pc;

  logic                pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic                if_id_flush, id_ex_flush, ex_mem_bubble, pc_sel, md_abort, md_err;
  logic [DATA_WID-1:0] new_pc;
  logic [CNT_W-1:0]    stall_cnt, flush_cnt;

  logic                pc_write_t, if_id_write_t, id_ex_write_t, ex_mem_write_t;
  logic                if_id_flush_t, id_ex_flush_t, ex_mem_bubble_t, pc_sel_t, md_abort_t, md_err_t;
  logic [DATA_WID-1:0] new_pc_t;
  logic [CNT_W-1:0]    stall_cnt_t, flush_cnt_t;

  logic [3:0] en, en_t;
  logic [1:0] fl;
  assign en   = {pc_write, if_id_write, id_ex_write, ex_mem_write};
  assign en_t = {pc_write_t, if_id_write_t, id_ex_write_t, ex_mem_write_t};
  assign fl   = {if_id_flush, id_ex_flush};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .ld_use(ld_use), .ex_mispredict(ex_mispredict),
    .ex_redirect_pc(ex_redirect_pc), .md_start(md_start), .md_done(md_done),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_bubble(ex_mem_bubble), .pc_sel(pc_sel), .new_pc(new_pc),
    .md_abort(md_abort), .md_err(md_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.MD_TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst), .ld_use(ld_use), .ex_mispredict(ex_mispredict),
    .ex_redirect_pc(ex_redirect_pc), .md_start(md_start), .md_done(md_done),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write_t), .if_id_write(if_id_write_t), .id_ex_write(id_ex_write_t),
    .ex_mem_write(ex_mem_write_t), .if_id_flush(if_id_flush_t), .id_ex_flush(id_ex_flush_t),
    .ex_mem_bubble(ex_mem_bubble_t), .pc_sel(pc_sel_t), .new_pc(new_pc_t),
    .md_abort(md_abort_t), .md_err(md_err_t), .stall_cnt(stall_cnt_t), .flush_cnt(flush_cnt_t)
  );

  always @(posedge clk)
    if (rst) assert (!(md_start && ex_mispredict)) else $error("illegal md_start with ex_mispredict");

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout need=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h need=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_use = 0; ex_mispredict = 0; md_start = 0; md_done = 0;
    mem_req = 0; mem_ready = 0; ex_redirect_pc = '0;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    // Reset holds outputs at zero even with hazards driven.
    ld_use = 1; ex_mispredict = 1; ex_redirect_pc = 32'h0000_0abc;
    tick(); tick(); #1;
    chk("rst_en", {28'd0, en}, 32'd0);
    chk("rst_pcsel", {31'd0, pc_sel}, 32'd0);
    chk("rst_newpc", new_pc, 32'd0);
    chk("rst_flush", {30'd0, fl}, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_flcnt", flush_cnt, 32'd0);
    chk("rst_err", {31'd0, md_err}, 32'd0);
    idle_inputs();
    tick();
    rst = 1;
    #1;
    chk("idle_en", {28'd0, en}, 32'hF);
    chk("idle_flush", {30'd0, fl}, 32'd0);

    // Load-use: one bubble.
    tick(); ld_use = 1; #1;
    chk("ldu_en", {28'd0, en}, 32'b0011);
    chk("ldu_flush", {30'd0, fl}, 32'b01);
    tick(); ld_use = 0; #1;
    chk("ldu_after_en", {28'd0, en}, 32'hF);
    chk("ldu_stall", stall_cnt, 32'd1);

    // Mispredict.
    ex_mispredict = 1; ex_redirect_pc = 32'h0000_0100; #1;
    chk("mp_pcsel", {31'd0, pc_sel}, 32'd1);
    chk("mp_newpc", new_pc, 32'h100);
    chk("mp_flush", {30'd0, fl}, 32'b11);
    chk("mp_en", {28'd0, en}, 32'hF);
    tick(); idle_inputs(); #1;
    chk("mp_flcnt", flush_cnt, 32'd1);
    chk("mp_pcsel_off", {31'd0, pc_sel}, 32'd0);

    // MMIO stall with a mispredict arriving while waiting.
    mem_req = 1; #1;
    chk("mem_c1_en", {28'd0, en}, 32'd0);
    tick(); ex_mispredict = 1; ex_redirect_pc = 32'h0000_0200; #1;
    chk("mem_c2_en", {28'd0, en}, 32'd0);
    chk("mem_c2_pcsel", {31'd0, pc_sel}, 32'd0);
    tick(); ex_mispredict = 0; ex_redirect_pc = '0; #1;
    chk("mem_c3_en", {28'd0, en}, 32'd0);
    tick(); mem_ready = 1; ld_use = 1; #1;
    chk("mem_rel_en", {28'd0, en}, 32'hF);
    chk("mem_rel_pcsel", {31'd0, pc_sel}, 32'd1);
    chk("mem_rel_newpc", new_pc, 32'h200);
    chk("mem_rel_flush", {30'd0, fl}, 32'b11);
    chk("mem_stall", stall_cnt, 32'd4);
    tick(); idle_inputs(); #1;
    chk("mem_post_en", {28'd0, en}, 32'hF);
    chk("mem_post_pcsel", {31'd0, pc_sel}, 32'd0);
    chk("mem_flcnt", flush_cnt, 32'd2);

    // Mul/div, done after 5 cycles; short-timeout instance aborts at its 4th wait cycle.
    md_start = 1; #1;
    chk("md_c0_en", {28'd0, en}, 32'b0001);
    chk("md_c0_bub", {31'd0, ex_mem_bubble}, 32'd1);
    tick(); md_start = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("md_wait_en", {28'd0, en}, 32'b0001);
      chk("md_wait_bub", {31'd0, ex_mem_bubble}, 32'd1);
      chk("md_wait_abort", {31'd0, md_abort}, 32'd0);
      chk("mdt_abort", {31'd0, md_abort_t}, (i == 4) ? 32'd1 : 32'd0);
      if (i == 4) begin
        chk("mdt_abort_en", {28'd0, en_t}, 32'hF);
        chk("mdt_abort_bub", {31'd0, ex_mem_bubble_t}, 32'd1);
      end
      tick();
    end
    md_done = 1; #1;
    chk("md_done_bub", {31'd0, ex_mem_bubble}, 32'd0);
    chk("md_done_en", {28'd0, en}, 32'hF);
    chk("mdt_err", {31'd0, md_err_t}, 32'd1);
    tick(); md_done = 0; #1;
    chk("md_run_en", {28'd0, en}, 32'hF);
    chk("md_stall", stall_cnt, 32'd9);
    chk("md_err", {31'd0, md_err}, 32'd0);

    // Done on the timeout cycle wins over abort.
    md_start = 1; tick(); md_start = 0;
    tick(); tick(); tick();
    md_done = 1; #1;
    chk("mdt_tie_abort", {31'd0, md_abort_t}, 32'd0);
    chk("mdt_tie_bub", {31'd0, ex_mem_bubble_t}, 32'd0);
    chk("mdt_tie_en", {28'd0, en_t}, 32'hF);
    tick(); md_done = 0;

    // Minimum occupancy: done on the first wait cycle.
    md_start = 1; tick(); md_start = 0; md_done = 1; #1;
    chk("md_min_bub", {31'd0, ex_mem_bubble}, 32'd0);
    chk("md_min_en", {28'd0, en}, 32'hF);
    tick(); md_done = 0; #1;
    chk("mdt_err_sticky", {31'd0, md_err_t}, 32'd1);

    // Reset during MEM_WAIT drops the pending redirect.
    mem_req = 1; ex_mispredict = 1; ex_redirect_pc = 32'h0000_0300;
    tick(); ex_mispredict = 0; ex_redirect_pc = '0;
    tick(); rst = 0; #1;
    chk("mrst_en", {28'd0, en}, 32'd0);
    chk("mrst_newpc", new_pc, 32'd0);
    chk("mrst_stall", stall_cnt, 32'd0);
    chk("mrst_flcnt", flush_cnt, 32'd0);
    chk("mrst_err_t", {31'd0, md_err_t}, 32'd0);
    idle_inputs();
    tick(); rst = 1; #1;
    chk("mrst_run_en", {28'd0, en}, 32'hF);
    chk("mrst_run_pcsel", {31'd0, pc_sel}, 32'd0);
    tick(); #1;
    chk("mrst_run_stall", stall_cnt, 32'd0);
    chk("mrst_run_flcnt", flush_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
